// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: TX shifter plus oversampling RX with 2-FF sync and a one-byte holding register.
// TX start bit one cycle after an accepted txBegin, no queuing; an RX byte arriving while one is unread is dropped and flagged.
module uart_transceiver #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    output logic       uartTx,
    input  logic [7:0] txByte,
    input  logic       txBegin,
    output logic       txReady,
    input  logic       uartRx,
    output logic [7:0] rxByte,
    input  logic       rxClear,
    output logic       rxAvailable,
    output logic       rxOverrun,
    output logic       rxFramingError
);
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] BIT_HALF = 16'(CLKS_PER_BIT / 2);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rxState_t;

    txState_t    txState, txNext;
    logic [15:0] txCnt;
    logic [2:0]  txIdx;
    logic [7:0]  txShift;
    logic        txCntDone;
    logic        txAccept;

    assign txCntDone = (txCnt == 16'd0);
    assign txAccept  = (txState == TX_IDLE) && txBegin;

    always_ff @(posedge clock) begin
        if (reset) txState <= TX_IDLE;
        else       txState <= txNext;
    end

    always_comb begin
        txNext = txState;
        case (txState)
            TX_IDLE:  if (txAccept) txNext = TX_START;
            TX_START: if (txCntDone) txNext = TX_DATA;
            TX_DATA:  if (txCntDone && txIdx == 3'd7) txNext = TX_STOP;
            TX_STOP:  if (txCntDone) txNext = TX_IDLE;
            default:  txNext = TX_IDLE;
        endcase
    end

    always_comb begin
        uartTx  = 1'b1;
        txReady = 1'b0;
        case (txState)
            TX_IDLE:  txReady = 1'b1;
            TX_START: uartTx  = 1'b0;
            TX_DATA:  uartTx  = txShift[txIdx];
            default:  uartTx  = 1'b1;
        endcase
    end

    // Bit timer reloads on every bit boundary; txIdx wraps 7->0 as STOP begins.
    always_ff @(posedge clock) begin
        if (reset) begin
            txCnt   <= 16'd0;
            txIdx   <= 3'd0;
            txShift <= 8'd0;
        end else if (txState == TX_IDLE) begin
            if (txAccept) begin
                txShift <= txByte;
                txCnt   <= BIT_LAST;
                txIdx   <= 3'd0;
            end
        end else if (txCntDone) begin
            txCnt <= BIT_LAST;
            if (txState == TX_DATA) txIdx <= txIdx + 3'd1;
        end else begin
            txCnt <= txCnt - 16'd1;
        end
    end

    logic        rxMeta, rxS;
    rxState_t    rxState, rxNext;
    logic [15:0] rxCnt;
    logic [2:0]  rxIdx;
    logic [7:0]  rxShift;
    logic        rxCntDone;
    logic        rxSampleData, rxDeliver, rxStopLow;

    assign rxCntDone = (rxCnt == 16'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
        end else begin
            rxMeta <= uartRx;
            rxS    <= rxMeta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) rxState <= RX_IDLE;
        else       rxState <= rxNext;
    end

    always_comb begin
        rxNext = rxState;
        case (rxState)
            RX_IDLE:      if (!rxS) rxNext = RX_START;
            RX_START:     if (rxCntDone) rxNext = rxS ? RX_IDLE : RX_DATA;
            RX_DATA:      if (rxCntDone && rxIdx == 3'd7) rxNext = RX_STOP;
            RX_STOP:      if (rxCntDone) rxNext = rxS ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rxS) rxNext = RX_IDLE;
            default:      rxNext = RX_IDLE;
        endcase
    end

    always_comb begin
        rxSampleData = 1'b0;
        rxDeliver    = 1'b0;
        rxStopLow    = 1'b0;
        case (rxState)
            RX_DATA: rxSampleData = rxCntDone;
            RX_STOP: begin
                rxDeliver = rxCntDone && rxS;
                rxStopLow = rxCntDone && !rxS;
            end
            default: rxSampleData = 1'b0;
        endcase
    end

    // Idle keeps the half-bit preload so START begins counting from mid-bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            rxCnt   <= 16'd0;
            rxIdx   <= 3'd0;
            rxShift <= 8'd0;
        end else begin
            case (rxState)
                RX_IDLE:      rxCnt <= BIT_HALF;
                RX_WAIT_HIGH: rxCnt <= BIT_HALF;
                default: begin
                    if (rxCntDone) rxCnt <= BIT_LAST;
                    else           rxCnt <= rxCnt - 16'd1;
                    if (rxState == RX_START) rxIdx <= 3'd0;
                    if (rxSampleData) begin
                        rxShift <= {rxS, rxShift[7:1]};
                        rxIdx   <= rxIdx + 3'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rxByte         <= 8'd0;
            rxAvailable    <= 1'b0;
            rxOverrun      <= 1'b0;
            rxFramingError <= 1'b0;
        end else begin
            rxFramingError <= rxStopLow;
            if (rxDeliver && rxAvailable && !rxClear) begin
                rxOverrun <= 1'b1;
            end else if (rxDeliver) begin
                rxByte      <= rxShift;
                rxAvailable <= 1'b1;
                if (rxClear) rxOverrun <= 1'b0;
            end else if (rxClear) begin
                rxAvailable <= 1'b0;
                rxOverrun   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver at 8 clocks per bit: frame-level reference model, random bytes, loopback.
module tb_uart_transceiver;
    localparam int CPB = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       uartTx;
    logic [7:0] txByte = 8'd0;
    logic       txBegin = 1'b0;
    logic       txReady;
    logic       uartRx;
    logic [7:0] rxByte;
    logic       rxClear = 1'b0;
    logic       rxAvailable;
    logic       rxOverrun;
    logic       rxFramingError;

    logic rxDrive = 1'b1;
    logic loopback = 1'b0;
    logic glitch = 1'b0;
    int   nChecks = 0;
    int   nErrors = 0;
    int   cyc = 0;
    int   lastStart = 0;
    int   measLat = 80;

    assign uartRx = (loopback ? uartTx : rxDrive) & ~glitch;

    uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .reset(reset), .uartTx(uartTx), .txByte(txByte), .txBegin(txBegin),
        .txReady(txReady), .uartRx(uartRx), .rxByte(rxByte), .rxClear(rxClear),
        .rxAvailable(rxAvailable), .rxOverrun(rxOverrun), .rxFramingError(rxFramingError)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopBit);
        logic [9:0] f;
        f = {stopBit, b, 1'b0};
        tick();
        lastStart = cyc;
        for (int k = 0; k < 10; k++) begin
            rxDrive = f[k];
            repeat (CPB) @(posedge clock);
            #1;
        end
        rxDrive = 1'b1;
    endtask

    task automatic pulse_clear();
        tick();
        rxClear = 1'b1;
        tick();
        rxClear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        nChecks++;
        if ({rxByte, rxFramingError} !== 9'd0) begin
            nErrors++; $display("FAIL reset_rx: got byte %h ferr %b expected 00 0", rxByte, rxFramingError);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            nChecks++;
            if ({uartTx, txReady, rxAvailable, rxOverrun} !== 4'b1100) begin
                nErrors++; $display("FAIL reset_idle: cycle %0d got %b expected 1100", i, {uartTx, txReady, rxAvailable, rxOverrun});
            end
        end
    endtask

    task automatic test_tx(input logic [7:0] b, input bit tryIgnore);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 200 && txReady !== 1'b1; i++) tick();
        nChecks++;
        if (txReady !== 1'b1) begin nErrors++; $display("FAIL tx_ready_wait: got %b expected 1", txReady); end
        txByte = b;
        txBegin = 1'b1;
        tick();
        txBegin = 1'b0;
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clock);
            nChecks++;
            if ({uartTx, txReady} !== {f[i / CPB], 1'b0}) begin
                nErrors++; $display("FAIL tx_wave: byte %h cycle %0d got tx/rdy %b expected %b", b, i, {uartTx, txReady}, {f[i / CPB], 1'b0});
            end
            tick();
            txBegin = tryIgnore && (i == 8);
            if (tryIgnore && i == 8) txByte = ~b;
        end
        @(negedge clock);
        nChecks++;
        if ({uartTx, txReady} !== 2'b11) begin
            nErrors++; $display("FAIL tx_done: got tx/rdy %b expected 11", {uartTx, txReady});
        end
    endtask

    task automatic test_rx(input logic [7:0] b);
        bit got;
        int lat;
        got = 0;
        lat = 0;
        fork
            send_frame(b, 1'b1);
            for (int i = 0; i < 150 && !got; i++) begin
                @(negedge clock);
                if (rxAvailable === 1'b1) begin got = 1; lat = cyc - lastStart; end
            end
        join
        nChecks++;
        if (!got) begin nErrors++; $display("FAIL rx_timeout: byte %h never became available", b); end
        else measLat = lat;
        nChecks++;
        if (lat < 74 || lat > 84) begin nErrors++; $display("FAIL rx_latency: got %0d cycles expected 74..84", lat); end
        nChecks++;
        if (rxByte !== b) begin nErrors++; $display("FAIL rx_byte: got %h expected %h", rxByte, b); end
        pulse_clear();
        @(negedge clock);
        nChecks++;
        if ({rxAvailable, rxByte} !== {1'b0, b}) begin
            nErrors++; $display("FAIL rx_clear: got avail %b byte %h expected 0 %h", rxAvailable, rxByte, b);
        end
    endtask

    task automatic test_overrun(input logic [7:0] b1, input logic [7:0] b2);
        send_frame(b1, 1'b1);
        send_frame(b2, 1'b1);
        repeat (5) tick();
        @(negedge clock);
        nChecks++;
        if ({rxAvailable, rxOverrun, rxByte} !== {2'b11, b1}) begin
            nErrors++; $display("FAIL overrun_set: got avail %b ovr %b byte %h expected 1 1 %h", rxAvailable, rxOverrun, rxByte, b1);
        end
        pulse_clear();
        @(negedge clock);
        nChecks++;
        if ({rxAvailable, rxOverrun, rxByte} !== {2'b00, b1}) begin
            nErrors++; $display("FAIL overrun_clear: got avail %b ovr %b byte %h expected 0 0 %h", rxAvailable, rxOverrun, rxByte, b1);
        end
    endtask

    task automatic test_clear_on_delivery(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        int target;
        send_frame(a, 1'b1);
        send_frame(b, 1'b1);
        fork
            send_frame(c, 1'b1);
            begin
                @(posedge clock);
                #2;
                target = lastStart + measLat - 1;
                while (cyc < target) tick();
                rxClear = 1'b1;
                tick();
                rxClear = 1'b0;
            end
        join
        @(negedge clock);
        nChecks++;
        if ({rxAvailable, rxOverrun, rxByte} !== {2'b10, c}) begin
            nErrors++; $display("FAIL clear_on_delivery: got avail %b ovr %b byte %h expected 1 0 %h", rxAvailable, rxOverrun, rxByte, c);
        end
        pulse_clear();
        @(negedge clock);
        nChecks++;
        if (rxAvailable !== 1'b0) begin nErrors++; $display("FAIL clear_after_delivery: got avail %b expected 0", rxAvailable); end
    endtask

    task automatic test_framing(input logic [7:0] okByte);
        int ferrCycles, availCycles;
        ferrCycles = 0;
        availCycles = 0;
        fork
            begin
                send_frame(8'h55, 1'b0);
                repeat (20) tick();
            end
            for (int i = 0; i < 110; i++) begin
                @(negedge clock);
                if (rxFramingError === 1'b1) ferrCycles++;
                if (rxAvailable === 1'b1) availCycles++;
            end
        join
        nChecks++;
        if (ferrCycles != 1) begin nErrors++; $display("FAIL framing_pulse: got %0d cycles expected 1", ferrCycles); end
        nChecks++;
        if (availCycles != 0) begin nErrors++; $display("FAIL framing_avail: got %0d cycles expected 0", availCycles); end
        test_rx(okByte);
    endtask

    task automatic test_back_to_back(input logic [7:0] b1, input logic [7:0] b2);
        logic [9:0] f1, f2;
        logic [7:0] gotQ[$];
        logic       expBit;
        f1 = {1'b1, b1, 1'b0};
        f2 = {1'b1, b2, 1'b0};
        loopback = 1'b1;
        repeat (4) tick();
        txByte = b1;
        txBegin = 1'b1;
        tick();
        txByte = b2;
        fork
            begin
                for (int i = 0; i < 20 * CPB + 1; i++) begin
                    @(negedge clock);
                    if (i < 10 * CPB) expBit = f1[i / CPB];
                    else if (i == 10 * CPB) expBit = 1'b1;
                    else expBit = f2[(i - 10 * CPB - 1) / CPB];
                    nChecks++;
                    if ({uartTx, txReady} !== {expBit, i == 10 * CPB}) begin
                        nErrors++; $display("FAIL b2b_wave: cycle %0d got tx/rdy %b expected %b", i, {uartTx, txReady}, {expBit, i == 10 * CPB});
                    end
                    tick();
                    if (i == 10 * CPB) txBegin = 1'b0;
                end
            end
            for (int i = 0; i < 230; i++) begin
                @(negedge clock);
                if (rxAvailable === 1'b1) begin
                    gotQ.push_back(rxByte);
                    pulse_clear();
                end
            end
        join
        nChecks++;
        if (gotQ.size() != 2) begin
            nErrors++; $display("FAIL b2b_count: got %0d bytes expected 2", gotQ.size());
        end else begin
            nChecks++;
            if ({gotQ[0], gotQ[1]} !== {b1, b2}) begin
                nErrors++; $display("FAIL b2b_bytes: got %h %h expected %h %h", gotQ[0], gotQ[1], b1, b2);
            end
        end
        nChecks++;
        if (rxOverrun !== 1'b0) begin nErrors++; $display("FAIL b2b_overrun: got %b expected 0", rxOverrun); end
    endtask

    task automatic test_random_loopback(input int n);
        logic [7:0] b, mByte;
        logic       mAvail, mOver;
        loopback = 1'b1;
        pulse_clear();
        mAvail = 1'b0;
        mOver = 1'b0;
        mByte = rxByte;
        for (int k = 0; k < n; k++) begin
            b = 8'($urandom_range(0, 255));
            for (int i = 0; i < 200 && txReady !== 1'b1; i++) tick();
            txByte = b;
            txBegin = 1'b1;
            tick();
            txBegin = 1'b0;
            for (int i = 0; i < 200 && txReady !== 1'b1; i++) tick();
            repeat (10) tick();
            if (mAvail) mOver = 1'b1;
            else begin mByte = b; mAvail = 1'b1; end
            @(negedge clock);
            nChecks++;
            if ({rxAvailable, rxOverrun, rxByte} !== {mAvail, mOver, mByte}) begin
                nErrors++; $display("FAIL rand_rx: frame %0d got avail %b ovr %b byte %h expected %b %b %h",
                                    k, rxAvailable, rxOverrun, rxByte, mAvail, mOver, mByte);
            end
            if ($urandom_range(0, 2) != 0) begin
                pulse_clear();
                mAvail = 1'b0;
                mOver = 1'b0;
                @(negedge clock);
                nChecks++;
                if ({rxAvailable, rxOverrun, rxByte} !== {mAvail, mOver, mByte}) begin
                    nErrors++; $display("FAIL rand_clear: frame %0d got avail %b ovr %b byte %h expected %b %b %h",
                                        k, rxAvailable, rxOverrun, rxByte, mAvail, mOver, mByte);
                end
            end
        end
        pulse_clear();
    endtask

    task automatic test_loopback_glitch_reset();
        int availCycles, ferrCycles;
        bit got;
        loopback = 1'b1;
        pulse_clear();
        tick();
        glitch = 1'b1;
        repeat (3) tick();
        glitch = 1'b0;
        availCycles = 0;
        ferrCycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (rxAvailable === 1'b1) availCycles++;
            if (rxFramingError === 1'b1) ferrCycles++;
        end
        nChecks++;
        if ({availCycles, ferrCycles} != 64'd0) begin
            nErrors++; $display("FAIL glitch: got avail %0d ferr %0d cycles expected 0 0", availCycles, ferrCycles);
        end
        tick();
        txByte = 8'($urandom_range(0, 255));
        txBegin = 1'b1;
        tick();
        txBegin = 1'b0;
        repeat (40) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        nChecks++;
        if ({uartTx, txReady, rxAvailable} !== 3'b110) begin
            nErrors++; $display("FAIL reset_midframe: got tx/rdy/avail %b expected 110", {uartTx, txReady, rxAvailable});
        end
        tick();
        txByte = 8'h81;
        txBegin = 1'b1;
        tick();
        txBegin = 1'b0;
        got = 0;
        ferrCycles = 0;
        for (int i = 0; i < 150 && !got; i++) begin
            @(negedge clock);
            if (rxFramingError === 1'b1) ferrCycles++;
            if (rxAvailable === 1'b1) got = 1;
        end
        nChecks++;
        if (!got || rxByte !== 8'h81 || ferrCycles != 0) begin
            nErrors++; $display("FAIL loopback_after_reset: got avail %b byte %h ferr %0d expected 1 81 0", got, rxByte, ferrCycles);
        end
        pulse_clear();
    endtask

    initial begin
        test_reset();
        test_tx(8'hA5, 1'b1);
        test_tx(8'($urandom_range(0, 255)), 1'b0);
        test_rx(8'h3C);
        test_rx(8'($urandom_range(0, 255)));
        test_overrun(8'h11, 8'h22);
        test_clear_on_delivery(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        test_framing(8'h66);
        test_back_to_back(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        test_random_loopback(8);
        test_loopback_glitch_reset();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
- Full-duplex 8N1 UART serving as the byte-level serial front end for the SRAM loader/CPU-control block.
- That block writes bytes through a begin/ready transmit handshake and drains received bytes through an available/clear handshake.
- Contains a TX shifter, an RX oversampling receiver with a 2-FF input synchronizer, and a one-byte RX holding register with overrun detection.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200). Legal range 4..65535.

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- uartTx  out  1  serial transmit line, idle high
- txByte  in  8  byte to send; sampled only on an accepted txBegin
- txBegin  in  1  request to send txByte; accepted only when txReady=1
- txReady  out  1  transmitter idle and able to accept a byte
- uartRx  in  1  asynchronous serial receive line, idle high
- rxByte  out  8  last received byte; valid while rxAvailable=1
- rxClear  in  1  consumer acknowledge; drops rxAvailable
- rxAvailable  out  1  rxByte holds an unread byte
- rxOverrun  out  1  sticky: a complete byte was dropped because rxAvailable was already 1
- rxFramingError  out  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset (synchronous, active-high; cycle after reset asserted):
  - uartTx=1, txReady=1, rxAvailable=0, rxByte=0, rxOverrun=0, rxFramingError=0.
  - Synchronizer FFs are set to 1; both FSMs return to IDLE.
  - Reset mid-frame aborts the frame: uartTx is high on the next cycle and partial RX data is discarded.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - txBegin=1 with txReady=1 at edge T latches txByte.
  - From T+1: txReady=0 and uartTx=0 (start bit).
  - Each bit is held exactly CLKS_PER_BIT cycles; data is sent LSB first, then one stop bit (1).
  - txReady returns to 1 at T+1+10*CLKS_PER_BIT, which is also the first cycle of idle-high.
  - txBegin while txReady=0 is ignored; no queuing.
  - txBegin held high continuously sends back-to-back frames with no extra idle cycles.
- RX FSM, states IDLE -> START -> DATA -> STOP -> (WAIT_HIGH) -> IDLE. The FSM operates on the synchronized line rxS, which lags uartRx by 2 cycles.
  - IDLE: rxS=0 enters START and loads the bit counter with CLKS_PER_BIT/2 (integer divide).
  - START: when the counter expires, sample rxS. If 1 (glitch), return to IDLE. If 0, enter DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first into the shift register.
  - STOP: sample CLKS_PER_BIT cycles after the last data bit.
    - Stop=1: deliver the byte and go to IDLE.
    - Stop=0: pulse rxFramingError for 1 cycle, discard the byte, go to WAIT_HIGH (remain until rxS=1), then IDLE.
  - Delivery on cycle D: next cycle rxByte=new byte and rxAvailable=1. Exception: if rxAvailable=1 and rxClear=0 on D, rxByte is kept, the new byte is dropped, and rxOverrun is set.
  - rxClear=1 while no delivery is occurring: rxAvailable=0 next cycle; rxByte is unchanged; rxOverrun is cleared.
  - rxClear and delivery on the same cycle: the new byte is loaded, rxAvailable stays 1, no overrun is flagged, and rxOverrun is cleared.
  - rxClear while rxAvailable=0: no effect apart from clearing rxOverrun.
- Counters:
  - Bit counter is 16 bits wide and counts down to 0; no wrap beyond CLKS_PER_BIT-1.
  - Data bit index is 3 bits, 0..7.
- TX and RX are independent. Simultaneous activity is required, and loopback (uartTx tied to uartRx) must work.

Test Plan:
All scenarios use CLKS_PER_BIT=8.
1. Reset then idle -> uartTx=1, txReady=1, rxAvailable=0, rxOverrun=0 for 100 cycles.
2. txBegin one cycle with txByte=0xA5 at cycle T -> uartTx carries start, bits 1,0,1,0,0,1,0,1, stop; each bit lasts 8 cycles starting at T+1; txReady=1 at T+81. A second txBegin at T+10 is ignored.
3. Drive uartRx with frame 0x3C -> rxAvailable=1 and rxByte=0x3C about 78 cycles after the start edge (2-cycle sync delay plus 9.5 bit times). rxClear -> rxAvailable=0 next cycle.
4. Send two frames 0x11 then 0x22 without rxClear -> rxByte=0x11 and rxOverrun=1. rxClear -> rxOverrun=0.
5. Frame 0x55 with stop bit low, then line high -> one-cycle rxFramingError pulse; rxAvailable stays 0. A following valid frame 0x66 is received correctly.
6. Loopback, 3-cycle low glitch on uartRx, then reset asserted mid-TX frame -> glitch produces no byte; uartTx=1 and txReady=1 the cycle after reset; the loopback byte 0x81 sent after reset is received intact.
